// File: rtl/pc_ras_unit.sv
// -----------------------------------------------------------------------------
// pc_ras_unit
//
// Program counter with PC-relative branch, absolute jump, hold mode, and a
// circular hardware return-address stack (RAS) serving CALL/RET.
//
// NPC_OUT is the combinational next address, computed from the current PC,
// PCSEL, OFFSET/DIRECT and the stack top. PC_OUT is the registered current
// address. It loads NPC_OUT on a rising CLK edge when LD=1.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET_N  in   asynchronous active-low reset
//   LD       in   update enable; 0 freezes PC and stack
//   PCSEL    in   next-PC mode: 0 INC, 1 REL, 2 ABS, 3 CALL, 4 RET, 5 HOLD,
//                 6/7 INC
//   OFFSET   in   signed branch displacement (REL only)
//   DIRECT   in   absolute target (ABS/CALL only)
//   CLR_ERR  in   synchronous clear of the sticky RAS error flags
//   PC_OUT   out  current PC (registered)
//   NPC_OUT  out  next PC (combinational)
//   RAS_CNT  out  number of valid stack entries
//   RAS_OVF  out  sticky: push onto full stack occurred
//   RAS_UNF  out  sticky: pop from empty stack occurred
// -----------------------------------------------------------------------------
module pc_ras_unit #(
    parameter int                 ADDR_W    = 16,
    parameter int                 RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_VEC = {ADDR_W{1'b0}}
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic                           LD,
    input  logic [2:0]                     PCSEL,
    input  logic [ADDR_W-1:0]              OFFSET,
    input  logic [ADDR_W-1:0]              DIRECT,
    input  logic                           CLR_ERR,
    output logic [ADDR_W-1:0]              PC_OUT,
    output logic [ADDR_W-1:0]              NPC_OUT,
    output logic [$clog2(RAS_DEPTH+1)-1:0] RAS_CNT,
    output logic                           RAS_OVF,
    output logic                           RAS_UNF
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        SEL_INC  = 3'd0,
        SEL_REL  = 3'd1,
        SEL_ABS  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4,
        SEL_HOLD = 3'd5
    } pcsel_e;

    // Architectural state
    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [PTR_W-1:0]  sp_q,  sp_d;   // next free slot; top is sp_q-1
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [RAS_DEPTH];

    // Decode results
    logic [ADDR_W-1:0] inc_s;
    logic [ADDR_W-1:0] top_s;
    logic [ADDR_W-1:0] npc_s;
    logic              push_s;
    logic              pop_s;
    logic              unf_evt_s;
    logic              full_s;

    assign inc_s  = pc_q + ADDR_W'(1);
    assign top_s  = stack_q[sp_q - PTR_W'(1)];
    assign full_s = (cnt_q == DEPTH_C);

    // Next-PC decode and stack operation request
    always_comb begin
        npc_s     = inc_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        unf_evt_s = 1'b0;
        case (PCSEL)
            SEL_INC:  npc_s = inc_s;
            SEL_REL:  npc_s = pc_q + OFFSET;
            SEL_ABS:  npc_s = DIRECT;
            SEL_CALL: begin
                npc_s  = DIRECT;
                push_s = 1'b1;
            end
            SEL_RET: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    npc_s = top_s;
                    pop_s = 1'b1;
                end else begin
                    // Empty stack: fall through to the next sequential address
                    npc_s     = inc_s;
                    unf_evt_s = 1'b1;
                end
            end
            SEL_HOLD: npc_s = pc_q;
            default:  npc_s = inc_s;
        endcase
    end

    // Next-state for PC, stack pointer, entry count and sticky flags
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (LD) begin
            pc_d = npc_s;
        end else begin
            pc_d = pc_q;
        end
        if (LD && push_s) begin
            // A full stack keeps its count; the oldest entry is overwritten
            sp_d = sp_q + PTR_W'(1);
            if (full_s) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (LD && pop_s) begin
            sp_d  = sp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            sp_d  = sp_q;
            cnt_d = cnt_q;
        end
        // A new error event in the same cycle as CLR_ERR leaves the flag set
        ovf_d = (CLR_ERR ? 1'b0 : ovf_q) | (LD & push_s & full_s);
        unf_d = (CLR_ERR ? 1'b0 : unf_q) | (LD & unf_evt_s);
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q  <= RESET_VEC;
            sp_q  <= {PTR_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage; entries are invalidated by the count, so no reset is needed
    always_ff @(posedge CLK) begin
        if (LD && push_s) begin
            stack_q[sp_q] <= inc_s;
        end
    end

    assign PC_OUT  = pc_q;
    assign NPC_OUT = npc_s;
    assign RAS_CNT = cnt_q;
    assign RAS_OVF = ovf_q;
    assign RAS_UNF = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_ras_unit: directed scenarios plus randomized stimulus for pc_ras_unit,
// checked against a queue-based reference model of the PC and return stack.
// -----------------------------------------------------------------------------
module tb_pc_ras_unit;

    localparam int D = 4;

    logic        CLK;
    logic        RESET_N;
    logic        LD;
    logic [2:0]  PCSEL;
    logic [15:0] OFFSET;
    logic [15:0] DIRECT;
    logic        CLR_ERR;
    logic [15:0] PC_OUT;
    logic [15:0] NPC_OUT;
    logic [2:0]  RAS_CNT;
    logic        RAS_OVF;
    logic        RAS_UNF;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_stk [$];
    bit          m_ovf;
    bit          m_unf;

    pc_ras_unit #(.ADDR_W(16), .RAS_DEPTH(D), .RESET_VEC(16'h0000)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .LD(LD), .PCSEL(PCSEL),
        .OFFSET(OFFSET), .DIRECT(DIRECT), .CLR_ERR(CLR_ERR),
        .PC_OUT(PC_OUT), .NPC_OUT(NPC_OUT), .RAS_CNT(RAS_CNT),
        .RAS_OVF(RAS_OVF), .RAS_UNF(RAS_UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_pc = 16'h0000;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic logic [15:0] m_npc();
        case (PCSEL)
            3'd1:    return m_pc + OFFSET;
            3'd2:    return DIRECT;
            3'd3:    return DIRECT;
            3'd4:    return (m_stk.size() > 0) ? m_stk[$] : m_pc + 16'd1;
            3'd5:    return m_pc;
            default: return m_pc + 16'd1;
        endcase
    endfunction

    task automatic drive(input bit ld, input logic [2:0] sel,
                         input logic [15:0] off, input logic [15:0] dir, input bit clr);
        LD = ld; PCSEL = sel; OFFSET = off; DIRECT = dir; CLR_ERR = clr;
    endtask

    // Advance one clock and apply the same update to the model
    task automatic tick();
        @(posedge CLK);
        if (CLR_ERR) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (LD) begin
            case (PCSEL)
                3'd1: m_pc = m_pc + OFFSET;
                3'd2: m_pc = DIRECT;
                3'd3: begin
                    m_stk.push_back(m_pc + 16'd1);
                    if (m_stk.size() > D) begin m_stk.delete(0); m_ovf = 1'b1; end
                    m_pc = DIRECT;
                end
                3'd4: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin m_pc = m_pc + 16'd1; m_unf = 1'b1; end
                end
                3'd5: m_pc = m_pc;
                default: m_pc = m_pc + 16'd1;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        drive(1'b1, 3'd0, 16'h0, 16'h0, 1'b0);
        model_reset();
        #12;
        total_cnt++; if (PC_OUT !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", PC_OUT); else pass_cnt++;
        total_cnt++; if (RAS_CNT !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", RAS_CNT); else pass_cnt++;
        total_cnt++; if (RAS_OVF !== 1'b0 || RAS_UNF !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", RAS_OVF, RAS_UNF); else pass_cnt++;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total_cnt++; if (PC_OUT !== 16'(i)) $display("FAIL inc_%0d: got %h want %h", i, PC_OUT, 16'(i)); else pass_cnt++;
        end
        drive(1'b1, 3'd5, 16'h1234, 16'h5678, 1'b0);
        tick();
        total_cnt++; if (PC_OUT !== 16'h0003) $display("FAIL hold: got %h want 0003", PC_OUT); else pass_cnt++;
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        #1;
        total_cnt++; if (NPC_OUT !== 16'h0004) $display("FAIL ld0_npc: got %h want 0004", NPC_OUT); else pass_cnt++;
        tick();
        total_cnt++; if (PC_OUT !== 16'h0003) $display("FAIL ld0_hold: got %h want 0003", PC_OUT); else pass_cnt++;
    endtask

    task automatic test_rel_abs_wrap();
        drive(1'b1, 3'd2, 16'h0, 16'h0010, 1'b0); tick();
        drive(1'b1, 3'd1, 16'hFFF8, 16'hABCD, 1'b0); #1;
        total_cnt++; if (NPC_OUT !== 16'h0008) $display("FAIL rel_npc: got %h want 0008", NPC_OUT); else pass_cnt++;
        tick();
        total_cnt++; if (PC_OUT !== 16'h0008) $display("FAIL rel_back: got %h want 0008", PC_OUT); else pass_cnt++;
        drive(1'b1, 3'd2, 16'h0, 16'h0002, 1'b0); tick();
        drive(1'b1, 3'd1, 16'hFFFD, 16'h0, 1'b0); tick();
        total_cnt++; if (PC_OUT !== 16'hFFFF) $display("FAIL rel_wrap: got %h want ffff", PC_OUT); else pass_cnt++;
        drive(1'b1, 3'd2, 16'h0, 16'hFFFF, 1'b0); tick();
        total_cnt++; if (PC_OUT !== 16'hFFFF) $display("FAIL abs: got %h want ffff", PC_OUT); else pass_cnt++;
        drive(1'b1, 3'd6, 16'h0, 16'h0, 1'b0); tick();
        total_cnt++; if (PC_OUT !== 16'h0000) $display("FAIL inc_wrap: got %h want 0000", PC_OUT); else pass_cnt++;
        drive(1'b1, 3'd7, 16'h0, 16'h0, 1'b0); tick();
        total_cnt++; if (PC_OUT !== 16'h0001) $display("FAIL sel7_inc: got %h want 0001", PC_OUT); else pass_cnt++;
    endtask

    task automatic test_call_ret();
        logic [15:0] exp_pc [4];
        logic [2:0]  exp_cnt [4];
        logic [2:0]  sel [4];
        logic [15:0] dir [4];
        exp_pc  = '{16'h0200, 16'h0300, 16'h0201, 16'h0101};
        exp_cnt = '{3'd1, 3'd2, 3'd1, 3'd0};
        sel     = '{3'd3, 3'd3, 3'd4, 3'd4};
        dir     = '{16'h0200, 16'h0300, 16'h0, 16'h0};
        drive(1'b1, 3'd2, 16'h0, 16'h0100, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sel[i], 16'h7777, dir[i], 1'b0); tick();
            total_cnt++; if (PC_OUT !== exp_pc[i]) $display("FAIL nest_pc%0d: got %h want %h", i, PC_OUT, exp_pc[i]); else pass_cnt++;
            total_cnt++; if (RAS_CNT !== exp_cnt[i]) $display("FAIL nest_cnt%0d: got %0d want %0d", i, RAS_CNT, exp_cnt[i]); else pass_cnt++;
        end
        total_cnt++; if (RAS_OVF !== 1'b0 || RAS_UNF !== 1'b0) $display("FAIL nest_flags: got %b%b want 00", RAS_OVF, RAS_UNF); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [15:0] want;
        drive(1'b1, 3'd2, 16'h0, 16'h1000, 1'b0); tick();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 3'd3, 16'h0, 16'h1000 + 16'(16 * i), 1'b0); tick();
        end
        total_cnt++; if (RAS_OVF !== 1'b1) $display("FAIL ovf_set: got %b want 1", RAS_OVF); else pass_cnt++;
        total_cnt++; if (RAS_CNT !== 3'd4) $display("FAIL ovf_cnt: got %0d want 4", RAS_CNT); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            want = 16'h1000 + 16'(16 * (4 - k)) + 16'd1;
            drive(1'b1, 3'd4, 16'h0, 16'h0, 1'b0); tick();
            total_cnt++; if (PC_OUT !== want) $display("FAIL ovf_ret%0d: got %h want %h", k, PC_OUT, want); else pass_cnt++;
        end
        total_cnt++; if (RAS_CNT !== 3'd0 || RAS_OVF !== 1'b1 || RAS_UNF !== 1'b0)
            $display("FAIL ovf_after: got cnt=%0d ovf=%b unf=%b want cnt=0 ovf=1 unf=0", RAS_CNT, RAS_OVF, RAS_UNF); else pass_cnt++;
    endtask

    task automatic test_underflow_clear();
        drive(1'b1, 3'd2, 16'h0, 16'h0040, 1'b1); tick();
        total_cnt++; if (RAS_OVF !== 1'b0) $display("FAIL clr_ovf: got %b want 0", RAS_OVF); else pass_cnt++;
        drive(1'b1, 3'd4, 16'h0, 16'h0, 1'b0); #1;
        total_cnt++; if (NPC_OUT !== 16'h0041) $display("FAIL unf_npc: got %h want 0041", NPC_OUT); else pass_cnt++;
        tick();
        total_cnt++; if (PC_OUT !== 16'h0041 || RAS_UNF !== 1'b1) $display("FAIL unf_set: got pc=%h unf=%b want pc=0041 unf=1", PC_OUT, RAS_UNF); else pass_cnt++;
        drive(1'b1, 3'd0, 16'h0, 16'h0, 1'b0); tick();
        total_cnt++; if (RAS_UNF !== 1'b1) $display("FAIL unf_sticky: got %b want 1", RAS_UNF); else pass_cnt++;
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b1); tick();
        total_cnt++; if (RAS_UNF !== 1'b0 || PC_OUT !== 16'h0042) $display("FAIL clr_ld0: got unf=%b pc=%h want unf=0 pc=0042", RAS_UNF, PC_OUT); else pass_cnt++;
        drive(1'b0, 3'd4, 16'h0, 16'h0, 1'b0); tick();
        total_cnt++; if (RAS_UNF !== 1'b0) $display("FAIL unf_ld0: got %b want 0", RAS_UNF); else pass_cnt++;
        drive(1'b1, 3'd4, 16'h0, 16'h0, 1'b1); tick();
        total_cnt++; if (RAS_UNF !== 1'b1 || PC_OUT !== 16'h0043) $display("FAIL set_wins: got unf=%b pc=%h want unf=1 pc=0043", RAS_UNF, PC_OUT); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 3'd0, 16'h0, 16'h0, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd3, 16'h0, 16'h0800 + 16'(i), 1'b0); tick();
        end
        total_cnt++; if (RAS_CNT !== 3'd3) $display("FAIL ar_pre_cnt: got %0d want 3", RAS_CNT); else pass_cnt++;
        #2 RESET_N = 1'b0;
        #1;
        total_cnt++; if (PC_OUT !== 16'h0000 || RAS_CNT !== 3'd0) $display("FAIL ar_async: got pc=%h cnt=%0d want 0000/0", PC_OUT, RAS_CNT); else pass_cnt++;
        model_reset();
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        drive(1'b1, 3'd4, 16'h0, 16'h0, 1'b0); tick();
        total_cnt++; if (PC_OUT !== 16'h0001 || RAS_UNF !== 1'b1) $display("FAIL ar_ret_unf: got pc=%h unf=%b want 0001/1", PC_OUT, RAS_UNF); else pass_cnt++;
    endtask

    task automatic test_random();
        int r;
        logic [15:0] exp_npc;
        drive(1'b1, 3'd0, 16'h0, 16'h0, 1'b1); tick();
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 11);
            drive($urandom_range(0, 7) != 0,
                  (r < 8) ? 3'(r) : ((r < 10) ? 3'd3 : 3'd4),
                  16'($urandom), 16'($urandom),
                  $urandom_range(0, 15) == 0);
            #1;
            exp_npc = m_npc();
            total_cnt++; if (NPC_OUT !== exp_npc) $display("FAIL rnd_npc@%0d: got %h want %h", n, NPC_OUT, exp_npc); else pass_cnt++;
            tick();
            total_cnt++;
            if (PC_OUT !== m_pc || RAS_CNT !== 3'(m_stk.size()) || RAS_OVF !== m_ovf || RAS_UNF !== m_unf)
                $display("FAIL rnd_state@%0d: got pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                         n, PC_OUT, RAS_CNT, RAS_OVF, RAS_UNF, m_pc, m_stk.size(), m_ovf, m_unf);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_rel_abs_wrap();
        test_call_ret();
        test_overflow();
        test_underflow_clear();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised next-generation program counter for the CPU datapath.
- Adds internal PC-relative branch computation, an explicit hold mode, and a hardware return-address stack (RAS) for CALL/RET with sticky overflow/underflow flags.
- Sits between the control unit (PCSEL/LD) and instruction memory address port; NPC_OUT is the combinational next address, PC_OUT the registered current address.

Parameters:
ADDR_W, 16, width of PC, OFFSET, DIRECT and all stack entries
RAS_DEPTH, 4, return-address stack entries; power of two, >= 2
RESET_VEC, 0, PC value loaded on reset

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
LD  input  1  update enable; 0 freezes PC and stack
PCSEL  input  3  next-PC mode select (see Behaviour)
OFFSET  input  ADDR_W  signed two's-complement branch displacement
DIRECT  input  ADDR_W  absolute target (jump/call)
CLR_ERR  input  1  synchronous clear of RAS_OVF/RAS_UNF
PC_OUT  output  ADDR_W  current PC (registered)
NPC_OUT  output  ADDR_W  next PC (combinational from PC, PCSEL, inputs, stack top)
RAS_CNT  output  $clog2(RAS_DEPTH+1)  valid stack entries
RAS_OVF  output  1  sticky: push onto full stack occurred
RAS_UNF  output  1  sticky: pop from empty stack occurred

Behaviour:
- One clock (CLK); reset asynchronous, active-low (RESET_N). While RESET_N=0: PC_OUT=RESET_VEC, RAS_CNT=0, RAS_OVF=0, RAS_UNF=0, stack pointer=0; stack contents don't-care. Reset mid-operation discards all stack entries immediately.
- PCSEL decode (NPC_OUT):
  - 0 INC: PC+1.
  - 1 REL: PC+OFFSET.
  - 2 ABS: DIRECT.
  - 3 CALL: DIRECT; push PC+1.
  - 4 RET: top-of-stack; pop.
  - 5 HOLD: PC.
  - 6, 7: treated as INC.
- All PC arithmetic is modulo 2^ADDR_W; carry discarded (0xFFFF+1 = 0x0000, 0x0002+0xFFFD = 0xFFFF).
- On rising CLK with LD=1: PC_OUT <= NPC_OUT and the stack operation commits.
- With LD=0: PC, stack, pointer and RAS_CNT are unchanged. No push/pop occurs and no error flags are set. NPC_OUT still reflects the decode.
- Latency: NPC_OUT is valid in the same cycle as its inputs; PC_OUT reflects it one cycle later.
- Stack is circular, RAS_DEPTH entries; pointer wraps modulo RAS_DEPTH.
  - Push when RAS_CNT<RAS_DEPTH: write entry, increment pointer and RAS_CNT.
  - Push when full (RAS_CNT=RAS_DEPTH): overwrite oldest entry, pointer advances, RAS_CNT stays at RAS_DEPTH, RAS_OVF<=1.
  - Pop when RAS_CNT>0: NPC_OUT = most recent entry; decrement pointer and RAS_CNT.
  - Pop when empty (RAS_CNT=0): NPC_OUT = PC+1 (fall-through), pointer and RAS_CNT unchanged, RAS_UNF<=1.
- Error flags are sticky until reset or CLR_ERR=1 at a clock edge. CLR_ERR acts regardless of LD. If CLR_ERR and a new error event occur in the same cycle, the flag ends at 1 (set wins).
- RET immediately after CALL (consecutive cycles, LD=1) returns the address pushed by that CALL; no bypass bubble required.
- OFFSET and DIRECT are ignored in modes that don't use them.

Test Plan:
- Reset/INC: RESET_N low then release, LD=1, PCSEL=0 for 3 cycles -> PC_OUT 0x0000,0x0001,0x0002,0x0003. PCSEL=5 -> PC_OUT holds 0x0003. LD=0 with PCSEL=0 -> holds.
- REL/ABS/wrap: PC=0x0010, OFFSET=0xFFF8 -> 0x0008. ABS DIRECT=0xFFFF then INC -> 0xFFFF, 0x0000.
- CALL/RET nesting: at PC=0x0100 CALL 0x0200; at 0x0200 CALL 0x0300; RET, RET -> PC 0x0200, 0x0300, 0x0201, 0x0101. RAS_CNT 1,2,1,0. No flags.
- Overflow: 5 CALLs (DEPTH=4) from PCs A0..A4 -> RAS_OVF=1, RAS_CNT=4. Then 4 RETs -> A4+1, A3+1, A2+1, A1+1 (A0+1 lost).
- Underflow/clear: RET at PC=0x0040 with empty stack -> PC 0x0041, RAS_UNF=1 and stays set. CLR_ERR=1 alone -> 0. CLR_ERR together with an empty RET -> stays 1.
- Async reset mid-stack: RAS_CNT=3, drop RESET_N between clock edges -> PC_OUT=RESET_VEC and RAS_CNT=0 without a clock edge. A following RET -> underflow.
